// File: rtl/fft4_2d_tile_loader.sv
// -----------------------------------------------------------------------------
// fft4_2d_tile_loader
//
// Upstream feeder for the 4x4 2D FFT stage. Collects a valid/ready stream of
// complex samples (row-major, one per cycle) into a 16-entry fill buffer and
// publishes each completed tile as a parallel register bank, together with a
// one-cycle tile_next strobe. Consecutive strobes are spaced at least MIN_GAP
// cycles apart. A frame closed early by in_last is zero-padded to 16 entries.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     input sample valid
//   in_ready     loader can accept a sample this cycle
//   in_re/in_im  sample real / imaginary part (DATA_W, two's complement)
//   in_last      sample closes the current tile (early close -> zero pad)
//   tile_re      16 real parts, element [i][j] at bits (4*i+j)*DATA_W +: DATA_W
//   tile_im      16 imaginary parts, same layout as tile_re
//   tile_next    one-cycle strobe: a new tile is on tile_re/tile_im
//   tile_padded  the current tile was closed early (held with the tile)
// -----------------------------------------------------------------------------
module fft4_2d_tile_loader #(
   parameter int DATA_W  = 16,
   parameter int MIN_GAP = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_re,
   input  logic [DATA_W-1:0]    in_im,
   input  logic                 in_last,
   output logic [16*DATA_W-1:0] tile_re,
   output logic [16*DATA_W-1:0] tile_im,
   output logic                 tile_next,
   output logic                 tile_padded
);

   localparam int N     = 16;
   localparam int GAP_W = $clog2(MIN_GAP + 1);

   typedef enum logic {
      FILL = 1'b0,
      PEND = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          idx_q, idx_d;
   logic [3:0]          last_q, last_d;      // last accepted index of the pending tile
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [DATA_W-1:0]   fill_re_q [N];
   logic [DATA_W-1:0]   fill_im_q [N];
   logic [N*DATA_W-1:0] tile_re_q, tile_re_d;
   logic [N*DATA_W-1:0] tile_im_q, tile_im_d;
   logic                next_q, next_d;
   logic                pad_q, pad_d;

   logic                accept, complete, gap_ok;
   logic                emit, emit_now;
   logic [3:0]          emit_last;

   // Reset is asynchronous, so the state register already reads FILL while
   // reset is held; in_ready must be gated explicitly.
   assign in_ready = (state_q == FILL) && !reset;
   assign accept   = in_valid && in_ready;
   assign complete = accept && ((idx_q == 4'd15) || in_last);
   assign gap_ok   = (gap_q >= GAP_W'(MIN_GAP));

   // Next-state logic
   // NOTE: every variable gets a default before the case so no path leaves
   // it unassigned; otherwise a latch is inferred.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      last_d    = last_q;
      emit      = 1'b0;
      emit_now  = 1'b0;
      emit_last = last_q;
      case (state_q)
         FILL: begin
            if (accept) idx_d = idx_q + 4'd1;
            if (complete) begin
               idx_d  = '0;
               last_d = idx_q;
               if (gap_ok) begin
                  emit      = 1'b1;
                  emit_now  = 1'b1;
                  emit_last = idx_q;
               end else begin
                  state_d = PEND;
               end
            end
         end
         PEND: begin
            if (gap_ok) begin
               emit    = 1'b1;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // Tile bank, strobe and gap counter
   always_comb begin
      tile_re_d = tile_re_q;
      tile_im_d = tile_im_q;
      pad_d     = pad_q;
      next_d    = emit;
      if (emit)        gap_d = GAP_W'(1);
      else if (!gap_ok) gap_d = gap_q + GAP_W'(1);
      else             gap_d = gap_q;

      if (emit) begin
         pad_d = (emit_last != 4'd15);
         for (int k = 0; k < N; k++) begin
            // Entries past the last accepted index are masked to zero; the
            // fill buffer itself is never cleared between tiles.
            if (4'(k) > emit_last) begin
               tile_re_d[k*DATA_W +: DATA_W] = '0;
               tile_im_d[k*DATA_W +: DATA_W] = '0;
            end else if (emit_now && (4'(k) == idx_q)) begin
               // Completing sample is not in the fill buffer yet.
               tile_re_d[k*DATA_W +: DATA_W] = in_re;
               tile_im_d[k*DATA_W +: DATA_W] = in_im;
            end else begin
               tile_re_d[k*DATA_W +: DATA_W] = fill_re_q[k];
               tile_im_d[k*DATA_W +: DATA_W] = fill_im_q[k];
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= FILL;
         idx_q     <= '0;
         last_q    <= '0;
         gap_q     <= GAP_W'(MIN_GAP);
         tile_re_q <= '0;
         tile_im_q <= '0;
         next_q    <= 1'b0;
         pad_q     <= 1'b0;
         // NOTE: the fill buffer is small and must read zero after reset, so
         // it is built from reset flops rather than an inferred RAM.
         for (int k = 0; k < N; k++) begin
            fill_re_q[k] <= '0;
            fill_im_q[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         gap_q     <= gap_d;
         tile_re_q <= tile_re_d;
         tile_im_q <= tile_im_d;
         next_q    <= next_d;
         pad_q     <= pad_d;
         if (accept) begin
            fill_re_q[idx_q] <= in_re;
            fill_im_q[idx_q] <= in_im;
         end
      end
   end

   assign tile_re     = tile_re_q;
   assign tile_im     = tile_im_q;
   assign tile_next   = next_q;
   assign tile_padded = pad_q;

endmodule

// File: tb/tb_fft4_2d_tile_loader.sv
// -----------------------------------------------------------------------------
// tb_fft4_2d_tile_loader
//
// Two loaders side by side: dut 0 with MIN_GAP=16, dut 1 with MIN_GAP=20.
// A frame-level reference model (sample lists, strobe timestamps) predicts
// in_ready, tile_next, tile_padded and the tile bank; a compare thread checks
// every cycle on the falling edge, and directed phases pin the model with
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_fft4_2d_tile_loader;

   localparam int DW = 16;
   localparam int TW = 16 * DW;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid    [2];
   logic          in_ready    [2];
   logic [DW-1:0] in_re       [2];
   logic [DW-1:0] in_im       [2];
   logic          in_last     [2];
   logic [TW-1:0] tile_re     [2];
   logic [TW-1:0] tile_im     [2];
   logic          tile_next   [2];
   logic          tile_padded [2];

   always #5 clk = ~clk;

   fft4_2d_tile_loader #(.DATA_W(DW), .MIN_GAP(16)) u_dut_g16 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_re(in_re[0]), .in_im(in_im[0]), .in_last(in_last[0]),
      .tile_re(tile_re[0]), .tile_im(tile_im[0]),
      .tile_next(tile_next[0]), .tile_padded(tile_padded[0])
   );

   fft4_2d_tile_loader #(.DATA_W(DW), .MIN_GAP(20)) u_dut_g20 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_re(in_re[1]), .in_im(in_im[1]), .in_last(in_last[1]),
      .tile_re(tile_re[1]), .tile_im(tile_im[1]),
      .tile_next(tile_next[1]), .tile_padded(tile_padded[1])
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit done    = 1'b0;

   // ---------------- reference model state ----------------
   logic [DW-1:0] m_re [2][16];   // published tile
   logic [DW-1:0] m_im [2][16];
   logic          m_pad  [2];
   logic          m_next [2];
   logic          m_pend [2];     // a completed tile waits for the gap
   logic [DW-1:0] p_re [2][16];   // completed tile awaiting publication
   logic [DW-1:0] p_im [2][16];
   logic          p_pad [2];
   logic [DW-1:0] c_re [2][16];   // samples collected for the current frame
   logic [DW-1:0] c_im [2][16];
   int            c_n   [2];
   bit            seen  [2];
   longint        last_t[2];

   // observations for the directed checks
   int     n_strobe [2];
   int     n_low    [2];
   longint strobe_t [2];
   longint prev_t   [2];

   function automatic int min_gap(input int d);
      return (d == 0) ? 16 : 20;
   endfunction

   function automatic logic [DW-1:0] el(input logic [TW-1:0] v, input int k);
      return v[k*DW +: DW];
   endfunction

   task automatic check(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 16; k++) begin
            m_re[d][k] = '0; m_im[d][k] = '0;
            p_re[d][k] = '0; p_im[d][k] = '0;
            c_re[d][k] = '0; c_im[d][k] = '0;
         end
         m_pad[d]  = 1'b0;
         m_next[d] = 1'b0;
         m_pend[d] = 1'b0;
         p_pad[d]  = 1'b0;
         c_n[d]    = 0;
         seen[d]   = 1'b0;
         last_t[d] = 0;
      end
   endtask

   // One clock edge: accept per the handshake, close frames, publish a tile
   // once at least min_gap clock periods have passed since the last one.
   task automatic model_clock();
      for (int d = 0; d < 2; d++) begin
         m_next[d] = 1'b0;
         if (!m_pend[d] && in_valid[d]) begin
            c_re[d][c_n[d]] = in_re[d];
            c_im[d][c_n[d]] = in_im[d];
            c_n[d]++;
            if (c_n[d] == 16 || in_last[d]) begin
               for (int k = 0; k < 16; k++) begin
                  p_re[d][k] = (k < c_n[d]) ? c_re[d][k] : '0;
                  p_im[d][k] = (k < c_n[d]) ? c_im[d][k] : '0;
               end
               p_pad[d]  = (c_n[d] < 16);
               c_n[d]    = 0;
               m_pend[d] = 1'b1;
            end
         end
         if (m_pend[d] && (!seen[d] || ($time - last_t[d] >= longint'(min_gap(d) * 10)))) begin
            for (int k = 0; k < 16; k++) begin
               m_re[d][k] = p_re[d][k];
               m_im[d][k] = p_im[d][k];
            end
            m_pad[d]  = p_pad[d];
            m_next[d] = 1'b1;
            m_pend[d] = 1'b0;
            seen[d]   = 1'b1;
            last_t[d] = $time;
         end
      end
   endtask

   task automatic compare_cycle();
      logic [TW-1:0] er, ei;
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 16; k++) begin
            er[k*DW +: DW] = m_re[d][k];
            ei[k*DW +: DW] = m_im[d][k];
         end
         check($sformatf("dut%0d in_ready", d),    TW'(in_ready[d]),    TW'(!reset && !m_pend[d]));
         check($sformatf("dut%0d tile_next", d),   TW'(tile_next[d]),   TW'(m_next[d]));
         check($sformatf("dut%0d tile_padded", d), TW'(tile_padded[d]), TW'(m_pad[d]));
         check($sformatf("dut%0d tile_re", d),     tile_re[d],          er);
         check($sformatf("dut%0d tile_im", d),     tile_im[d],          ei);
         if (tile_next[d] === 1'b1) begin
            n_strobe[d]++;
            prev_t[d]   = strobe_t[d];
            strobe_t[d] = $time;
         end
         if (!reset && in_ready[d] !== 1'b1) n_low[d]++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one sample and hold it until accepted (bounded wait).
   task automatic send(input int d, input logic [DW-1:0] re, input logic [DW-1:0] im,
                       input logic last, input bit rnd_gap);
      int  waited;
      logic r;
      if (rnd_gap) idle($urandom_range(0, 1) ? $urandom_range(1, 2) : 0);
      in_valid[d] = 1'b1;
      in_re[d]    = re;
      in_im[d]    = im;
      in_last[d]  = last;
      waited      = 0;
      forever begin
         @(negedge clk);
         r = in_ready[d];
         @(posedge clk);
         #1;
         if (r === 1'b1) break;
         waited++;
         if (waited > 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL send timeout dut%0d: in_ready stayed %b, required 1", d, r);
            break;
         end
      end
      in_valid[d] = 1'b0;
      in_last[d]  = 1'b0;
   endtask

   task automatic stimulus();
      int s0, l0;
      logic [TW-1:0] ref_re, ref_im;

      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0; in_re[d] = '0; in_im[d] = '0; in_last[d] = 1'b0;
      end
      idle(3);
      check("reset tile_re", tile_re[0], '0);
      check("reset in_ready", TW'(in_ready[0]), '0);
      reset = 1'b0;
      idle(2);

      // Contiguous 0..15, re=k, im=-k.
      s0 = n_strobe[0]; l0 = n_low[0];
      for (int k = 0; k < 16; k++) send(0, DW'(k), DW'(-k), 1'b0, 1'b0);
      idle(3);
      check("t1 strobes",  TW'(n_strobe[0] - s0), TW'(1));
      check("t1 ready low", TW'(n_low[0] - l0), TW'(0));
      check("t1 re[2][3]", TW'(el(tile_re[0], 11)), TW'(11));
      check("t1 im[2][3]", TW'(el(tile_im[0], 11)), TW'(16'hFFF5));
      check("t1 padded",   TW'(tile_padded[0]), TW'(0));

      // Back-to-back 32 samples with MIN_GAP=16.
      idle(20);
      s0 = n_strobe[0]; l0 = n_low[0];
      for (int k = 0; k < 32; k++) send(0, DW'(k), ~DW'(k), 1'b0, 1'b0);
      idle(3);
      check("t2 strobes",  TW'(n_strobe[0] - s0), TW'(2));
      check("t2 spacing",  TW'(strobe_t[0] - prev_t[0]), TW'(160));
      check("t2 ready low", TW'(n_low[0] - l0), TW'(0));
      check("t2 re[0][0]", TW'(el(tile_re[0], 0)), TW'(16));
      check("t2 re[3][3]", TW'(el(tile_re[0], 15)), TW'(31));

      // Back-to-back 32 samples with MIN_GAP=20: second tile waits.
      s0 = n_strobe[1]; l0 = n_low[1];
      for (int k = 0; k < 32; k++) send(1, DW'(k + 1000), DW'(k), 1'b0, 1'b0);
      idle(25);
      check("t3 strobes",  TW'(n_strobe[1] - s0), TW'(2));
      check("t3 spacing",  TW'(strobe_t[1] - prev_t[1]), TW'(200));
      check("t3 ready low", TW'(n_low[1] - l0), TW'(4));
      check("t3 re[0][0]", TW'(el(tile_re[1], 0)), TW'(1016));

      // Short frame closed on the 6th sample, then a full tile.
      idle(20);
      for (int k = 1; k <= 6; k++) send(0, DW'(k), DW'(100 + k), (k == 6), 1'b0);
      idle(3);
      check("t4 re[0][0]", TW'(el(tile_re[0], 0)), TW'(1));
      check("t4 re[0][3]", TW'(el(tile_re[0], 3)), TW'(4));
      check("t4 re[1][1]", TW'(el(tile_re[0], 5)), TW'(6));
      check("t4 re[1][2]", TW'(el(tile_re[0], 6)), TW'(0));
      check("t4 im[3][3]", TW'(el(tile_im[0], 15)), TW'(0));
      check("t4 padded",   TW'(tile_padded[0]), TW'(1));
      idle(20);
      for (int k = 0; k < 16; k++) send(0, DW'(50 + k), DW'(k), 1'b0, 1'b0);
      idle(3);
      check("t4b padded",   TW'(tile_padded[0]), TW'(0));
      check("t4b re[1][2]", TW'(el(tile_re[0], 6)), TW'(56));
      check("t4b re[3][3]", TW'(el(tile_re[0], 15)), TW'(65));

      // Random gaps: content must equal the contiguous case.
      idle(20);
      s0 = n_strobe[0];
      for (int k = 0; k < 16; k++) begin
         ref_re[k*DW +: DW] = DW'(k);
         ref_im[k*DW +: DW] = DW'(-k);
         send(0, DW'(k), DW'(-k), 1'b0, 1'b1);
      end
      idle(3);
      check("t5 strobes", TW'(n_strobe[0] - s0), TW'(1));
      check("t5 tile_re", tile_re[0], ref_re);
      check("t5 tile_im", tile_im[0], ref_im);

      // Asynchronous reset after 9 accepts.
      idle(20);
      s0 = n_strobe[0];
      for (int k = 0; k < 9; k++) send(0, DW'(300 + k), DW'(k), 1'b0, 1'b0);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("rst in_ready now",  TW'(in_ready[0]), '0);
      check("rst tile_next now", TW'(tile_next[0]), '0);
      check("rst padded now",    TW'(tile_padded[0]), '0);
      check("rst tile_re now",   tile_re[0], '0);
      check("rst tile_im now",   tile_im[0], '0);
      idle(2);
      reset = 1'b0;
      idle(2);
      check("rst no strobe", TW'(n_strobe[0] - s0), TW'(0));
      for (int k = 0; k < 16; k++) send(0, DW'(200 + k), DW'(k), 1'b0, 1'b0);
      idle(3);
      check("t6 strobes",  TW'(n_strobe[0] - s0), TW'(1));
      check("t6 re[0][0]", TW'(el(tile_re[0], 0)), TW'(200));
      check("t6 re[3][3]", TW'(el(tile_re[0], 15)), TW'(215));

      // Random frames of random length on both loaders.
      for (int f = 0; f < 30; f++) begin
         int d, len;
         d   = f % 2;
         len = $urandom_range(1, 16);
         for (int k = 0; k < len; k++)
            send(d, DW'($urandom), DW'($urandom), (k == len - 1), 1'b1);
      end
      idle(30);
      done = 1'b1;
   endtask

   initial begin
      model_reset();
      for (int d = 0; d < 2; d++) begin
         n_strobe[d] = 0; n_low[d] = 0; strobe_t[d] = 0; prev_t[d] = 0;
      end
      fork
         stimulus();
         while (!done) begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_clock();
         end
         while (!done) begin
            @(negedge clk);
            compare_cycle();
         end
      join
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
